// File: rtl/transport_down_fifo.sv
// Downlink transport FIFO between the DMA AXI-Stream FIFO and the PAICore
// send port, with TX pause gating, end-of-frame done pulse and counters.
module transport_down_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_areset,
  output logic                     s_axis_tready,
  input  logic [DATA_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_hsked,
  input  logic                     i_send_available,
  input  logic                     i_tx_enable,
  output logic                     o_send_valid,
  output logic [DATA_W-1:0]        o_send_pdata,
  output logic                     o_tx_done,
  output logic [CNT_W-1:0]         o_word_cnt,
  output logic [CNT_W-1:0]         o_frame_cnt,
  output logic [$clog2(DEPTH):0]   o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            wr;
  logic            rd;
  logic            head_last;

  // tready looks only at the registered level, never at PAICore
  assign s_axis_tready = (level != FULL);
  assign wr            = s_axis_tvalid && s_axis_tready;
  assign s_axis_hsked  = wr;

  assign o_send_valid  = (level != '0) && i_tx_enable;
  assign rd            = o_send_valid && i_send_available;
  assign {head_last, o_send_pdata} = mem[rd_ptr];
  assign o_fifo_level  = level;

  always_ff @(posedge s_axis_aclk) begin
    if (wr) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      o_tx_done   <= 1'b0;
      o_word_cnt  <= '0;
      o_frame_cnt <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      o_tx_done <= rd && head_last;
      if (rd) o_word_cnt <= o_word_cnt + 1'b1;
      if (rd && head_last) o_frame_cnt <= o_frame_cnt + 1'b1;
    end
  end

endmodule
